// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared state, target encodings and slave-select helpers for the SPI arbiter
package spi_arb_pkg;
    localparam int NUM_REQ = 3;
    localparam int NUM_SS = 5;
    typedef enum logic [1:0] {IDLE, SETUP, XFER, GUARD} state_e;
    // Target code doubles as the ss_n bit index: {EEP,trig,ch3,ch2,ch1}
    typedef enum logic [2:0] {TGT_CH1, TGT_CH2, TGT_CH3, TGT_TRIG, TGT_EEP} tgt_e;
    function automatic logic tgt_valid(input logic [2:0] t);
        return t <= TGT_EEP;
    endfunction
    function automatic logic [NUM_SS-1:0] ss_sel(input logic [2:0] t);
        return ~(NUM_SS'(1) << t);
    endfunction
endpackage

// File: rtl/spi_arb_rr.sv
// rr_arb3: combinational three-way round-robin grant starting the search at ptr
module rr_arb3 import spi_arb_pkg::*; (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] gnt
);
    logic [NUM_REQ-1:0] r, p;
    assign r = ptr == 2'd1 ? {req[0], req[2:1]} : ptr == 2'd2 ? {req[1:0], req[2]} : req;
    assign p = r[0] ? 3'b001 : r[1] ? 3'b010 : r[2] ? 3'b100 : 3'b000;
    assign gnt = ptr == 2'd1 ? {p[1:0], p[2]} : ptr == 2'd2 ? {p[0], p[2:1]} : p;
endmodule

// File: rtl/spi_arb.sv
// spi_arb: round-robin arbiter sharing one SPI master among three requesters
module spi_arb import spi_arb_pkg::*; #(
    parameter int SETUP_CYC   = 2,
    parameter int GUARD_CYC   = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [47:0]          req_cmd,
    input  logic [8:0]           req_tgt,
    output logic [NUM_REQ-1:0]   done,
    output logic                 err,
    output logic [15:0]          rsp_data,
    output logic                 spi_wrt,
    output logic [15:0]          spi_cmd,
    input  logic                 spi_done,
    input  logic [15:0]          spi_rd,
    output logic [NUM_SS-1:0]    ss_n
);
    state_e state, state_n;
    logic [12:0] cnt;
    logic [1:0] ptr;
    logic [NUM_REQ-1:0] gnt, gnt_q;
    logic [2:0] tgt_g, tgt_q;
    logic [15:0] cmd_g;
    logic grant, xfer_ok, tmo, to_guard;

    rr_arb3 u_rr (.req(req), .ptr(ptr), .gnt(gnt));

    assign tgt_g = gnt[1] ? req_tgt[5:3] : gnt[2] ? req_tgt[8:6] : req_tgt[2:0];
    assign cmd_g = gnt[1] ? req_cmd[31:16] : gnt[2] ? req_cmd[47:32] : req_cmd[15:0];
    assign grant = state == IDLE && |req;
    // The spi_wrt cycle (cnt==0) cannot complete a transfer
    assign xfer_ok = state == XFER && cnt != '0 && spi_done;
    assign tmo = state == XFER && cnt == 13'(TIMEOUT_CYC - 1);
    assign to_guard = state != GUARD && state_n == GUARD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (grant) state_n = tgt_valid(tgt_g) ? SETUP : GUARD;
            SETUP: if (cnt == 13'(SETUP_CYC - 1)) state_n = XFER;
            XFER:  if (xfer_ok || tmo) state_n = GUARD;
            GUARD: if (cnt == 13'(GUARD_CYC - 1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ss_n = (state == SETUP || state == XFER) ? ss_sel(tgt_q) : '1;
        spi_wrt = state == XFER && cnt == '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ptr <= '0;
            gnt_q <= '0;
            tgt_q <= '0;
            spi_cmd <= '0;
            done <= '0;
            err <= 1'b0;
            rsp_data <= '0;
        end else begin
            cnt <= (state_n != state || state == IDLE) ? '0 : cnt + 13'd1;
            if (grant) begin
                gnt_q <= gnt;
                tgt_q <= tgt_g;
                spi_cmd <= cmd_g;
                ptr <= gnt[0] ? 2'd1 : gnt[1] ? 2'd2 : 2'd0;
            end
            done <= to_guard ? (state == IDLE ? gnt : gnt_q) : '0;
            err <= to_guard && !xfer_ok;
            if (xfer_ok) rsp_data <= spi_rd;
        end
    end
endmodule
